// File: rtl/issue_scheduler.sv
// Issue-stage scheduler: round-robin pick of ready RS entries
// for NUM_ALU ALU slots and one shared, multi-cycle LSU.
module issue_scheduler #(
    parameter int RS_ENTRIES = 16,
    parameter int NUM_ALU    = 3,
    parameter int MEM_LAT    = 3,
    localparam int IDX_W     = $clog2(RS_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [RS_ENTRIES-1:0]    rs_ready,
    input  logic [RS_ENTRIES-1:0]    rs_is_mem,
    output logic [NUM_ALU-1:0]       alu_grant_valid,
    output logic [NUM_ALU*IDX_W-1:0] alu_grant_idx,
    output logic                     lsu_grant_valid,
    output logic [IDX_W-1:0]         lsu_grant_idx,
    output logic [RS_ENTRIES-1:0]    rs_clear,
    output logic                     lsu_busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_t;

    lsu_state_t state_q;
    lsu_state_t state_n;

    logic [CNT_W-1:0] lsu_cnt;
    logic [CNT_W-1:0] lsu_cnt_n;

    logic [IDX_W-1:0] alu_ptr;
    logic [IDX_W-1:0] lsu_ptr;

    logic [RS_ENTRIES-1:0] elig;
    logic [RS_ENTRIES-1:0] alu_cand;
    logic [RS_ENTRIES-1:0] mem_cand;

    logic [NUM_ALU-1:0]       alu_v_n;
    logic [NUM_ALU*IDX_W-1:0] alu_idx_n;
    logic [IDX_W-1:0]         alu_last;

    logic             lsu_en;
    logic             lsu_v_n;
    logic [IDX_W-1:0] lsu_idx_n;

    logic [RS_ENTRIES-1:0] clear_n;

    // Entries granted last cycle are still asserted by the RS; mask them.
    always_comb begin
        elig     = rs_ready & ~rs_clear;
        alu_cand = elig & ~rs_is_mem;
        mem_cand = elig & rs_is_mem;
    end

    // ALU pick: first NUM_ALU non-mem hits scanning up from alu_ptr.
    always_comb begin
        int n;
        logic [IDX_W-1:0] idx;
        alu_v_n   = '0;
        alu_idx_n = '0;
        alu_last  = alu_ptr;
        n         = 0;
        idx       = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            idx = alu_ptr + IDX_W'(i);
            if (alu_cand[idx] && (n < NUM_ALU)) begin
                for (int k = 0; k < NUM_ALU; k++) begin
                    if (k == n) begin
                        alu_v_n[k]                  = 1'b1;
                        alu_idx_n[k*IDX_W +: IDX_W] = idx;
                    end
                end
                alu_last = idx;
                n        = n + 1;
            end
        end
    end

    // LSU pick: first mem hit from lsu_ptr, only when the LSU frees up.
    always_comb begin
        logic [IDX_W-1:0] idx;
        lsu_v_n   = 1'b0;
        lsu_idx_n = '0;
        idx       = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            idx = lsu_ptr + IDX_W'(i);
            if (lsu_en && !lsu_v_n && mem_cand[idx]) begin
                lsu_v_n   = 1'b1;
                lsu_idx_n = idx;
            end
        end
    end

    // One-hot OR of every entry picked this cycle.
    always_comb begin
        clear_n = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            if (alu_v_n[k]) begin
                clear_n[alu_idx_n[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        if (lsu_v_n) begin
            clear_n[lsu_idx_n] = 1'b1;
        end
    end

    // LSU occupancy FSM: a grant (re)loads MEM_LAT, else count down.
    always_comb begin
        state_n   = state_q;
        lsu_cnt_n = lsu_cnt;
        lsu_en    = (state_q == LSU_IDLE) || (lsu_cnt == CNT_W'(1));
        unique case (state_q)
            LSU_IDLE: begin
                if (lsu_v_n) begin
                    state_n   = LSU_BUSY;
                    lsu_cnt_n = CNT_W'(MEM_LAT);
                end
            end
            LSU_BUSY: begin
                if (lsu_v_n) begin
                    state_n   = LSU_BUSY;
                    lsu_cnt_n = CNT_W'(MEM_LAT);
                end else begin
                    lsu_cnt_n = lsu_cnt - CNT_W'(1);
                    if (lsu_cnt == CNT_W'(1)) begin
                        state_n = LSU_IDLE;
                    end
                end
            end
            default: begin
                state_n   = LSU_IDLE;
                lsu_cnt_n = '0;
            end
        endcase
    end

    // LSU state register; flush abandons any in-flight occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LSU_IDLE;
            lsu_cnt <= '0;
        end else if (flush) begin
            state_q <= LSU_IDLE;
            lsu_cnt <= '0;
        end else begin
            state_q <= state_n;
            lsu_cnt <= lsu_cnt_n;
        end
    end

    // Registered grants, clear vector and round-robin pointers.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            alu_grant_valid <= '0;
            alu_grant_idx   <= '0;
            lsu_grant_valid <= 1'b0;
            lsu_grant_idx   <= '0;
            rs_clear        <= '0;
            alu_ptr         <= '0;
            lsu_ptr         <= '0;
        end else begin
            alu_grant_valid <= alu_v_n;
            alu_grant_idx   <= alu_idx_n;
            lsu_grant_valid <= lsu_v_n;
            lsu_grant_idx   <= lsu_idx_n;
            rs_clear        <= clear_n;
            if (alu_v_n[0]) begin
                alu_ptr <= alu_last + IDX_W'(1);
            end
            if (lsu_v_n) begin
                lsu_ptr <= lsu_idx_n + IDX_W'(1);
            end
        end
    end

    assign lsu_busy = (state_q == LSU_BUSY);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with hand-computed
// grant expectations at default parameters.
module tb_issue_scheduler;

    localparam int RS = 16;
    localparam int NA = 3;
    localparam int IW = 4;

    logic          clk;
    logic          reset;
    logic          flush;
    logic [RS-1:0] rs_ready;
    logic [RS-1:0] rs_is_mem;
    logic [NA-1:0] alu_grant_valid;
    logic [NA*IW-1:0] alu_grant_idx;
    logic          lsu_grant_valid;
    logic [IW-1:0] lsu_grant_idx;
    logic [RS-1:0] rs_clear;
    logic          lsu_busy;

    int tests;
    int failed;

    issue_scheduler #(
        .RS_ENTRIES(16),
        .NUM_ALU(3),
        .MEM_LAT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .rs_ready(rs_ready),
        .rs_is_mem(rs_is_mem),
        .alu_grant_valid(alu_grant_valid),
        .alu_grant_idx(alu_grant_idx),
        .lsu_grant_valid(lsu_grant_valid),
        .lsu_grant_idx(lsu_grant_idx),
        .rs_clear(rs_clear),
        .lsu_busy(lsu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int k);
        return 32'(alu_grant_idx[k*IW +: IW]);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".alu_v"}, 32'(alu_grant_valid), 32'h0);
        check({tag, ".alu_idx"}, 32'(alu_grant_idx), 32'h0);
        check({tag, ".lsu_v"}, 32'(lsu_grant_valid), 32'h0);
        check({tag, ".lsu_idx"}, 32'(lsu_grant_idx), 32'h0);
        check({tag, ".clear"}, 32'(rs_clear), 32'h0);
        check({tag, ".busy"}, 32'(lsu_busy), 32'h0);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        rs_ready  = 16'hFFFF;
        rs_is_mem = 16'h0000;

        // 1: reset, then basic three-wide ALU issue
        step();
        step();
        check_zero("t1_reset");
        reset    = 1'b1;
        rs_ready = 16'h00F0;
        step();
        check("t1a.v", 32'(alu_grant_valid), 32'h7);
        check("t1a.s0", slot(0), 32'd4);
        check("t1a.s1", slot(1), 32'd5);
        check("t1a.s2", slot(2), 32'd6);
        check("t1a.clr", 32'(rs_clear), 32'h0070);
        check("t1a.lsu", 32'(lsu_grant_valid), 32'h0);
        rs_ready = 16'h0080;
        step();
        check("t1b.v", 32'(alu_grant_valid), 32'h1);
        check("t1b.s0", slot(0), 32'd7);
        check("t1b.s1", slot(1), 32'd0);
        check("t1b.clr", 32'(rs_clear), 32'h0080);
        rs_ready = 16'h0000;
        step();
        check("t1c.v", 32'(alu_grant_valid), 32'h0);

        // 2: walk alu_ptr to 14, then wrap
        rs_ready = 16'h2000;
        step();
        check("t2a.s0", slot(0), 32'd13);
        rs_ready = 16'h0000;
        step();
        rs_ready = 16'h8007;
        step();
        check("t2b.v", 32'(alu_grant_valid), 32'h7);
        check("t2b.s0", slot(0), 32'd15);
        check("t2b.s1", slot(1), 32'd0);
        check("t2b.s2", slot(2), 32'd1);
        rs_ready = 16'h0004;
        step();
        check("t2c.v", 32'(alu_grant_valid), 32'h1);
        check("t2c.s0", slot(0), 32'd2);
        rs_ready = 16'h0000;
        step();

        // 3: LSU spacing is MEM_LAT cycles
        rs_is_mem = 16'h0208;
        rs_ready  = 16'h0208;
        step();
        check("t3e.lv", 32'(lsu_grant_valid), 32'h1);
        check("t3e.li", 32'(lsu_grant_idx), 32'd3);
        check("t3e.busy", 32'(lsu_busy), 32'h1);
        check("t3e.alu", 32'(alu_grant_valid), 32'h0);
        check("t3e.clr", 32'(rs_clear), 32'h0008);
        rs_ready = 16'h0200;
        step();
        check("t3e1.lv", 32'(lsu_grant_valid), 32'h0);
        step();
        check("t3e2.lv", 32'(lsu_grant_valid), 32'h0);
        check("t3e2.busy", 32'(lsu_busy), 32'h1);
        step();
        check("t3e3.lv", 32'(lsu_grant_valid), 32'h1);
        check("t3e3.li", 32'(lsu_grant_idx), 32'd9);
        rs_ready = 16'h0000;
        step();
        step();
        step();
        check("t3d.busy", 32'(lsu_busy), 32'h0);

        // 4: full RS from reset
        reset     = 1'b0;
        rs_ready  = 16'hFFFF;
        rs_is_mem = 16'hAAAA;
        step();
        reset = 1'b1;
        step();
        check("t4a.v", 32'(alu_grant_valid), 32'h7);
        check("t4a.s0", slot(0), 32'd0);
        check("t4a.s1", slot(1), 32'd2);
        check("t4a.s2", slot(2), 32'd4);
        check("t4a.lv", 32'(lsu_grant_valid), 32'h1);
        check("t4a.li", 32'(lsu_grant_idx), 32'd1);
        check("t4a.clr", 32'(rs_clear), 32'h0017);
        step();
        check("t4b.s0", slot(0), 32'd6);
        check("t4b.s1", slot(1), 32'd8);
        check("t4b.s2", slot(2), 32'd10);
        check("t4b.lv", 32'(lsu_grant_valid), 32'h0);
        check("t4b.busy", 32'(lsu_busy), 32'h1);

        // 5: flush while LSU busy
        flush = 1'b1;
        step();
        check_zero("t5_flush");
        flush = 1'b0;
        step();
        check("t5r.s0", slot(0), 32'd0);
        check("t5r.s1", slot(1), 32'd2);
        check("t5r.s2", slot(2), 32'd4);
        check("t5r.li", 32'(lsu_grant_idx), 32'd1);
        check("t5r.lv", 32'(lsu_grant_valid), 32'h1);
        step();

        // 6: reset together with flush mid-burst
        check("t6.busy_pre", 32'(lsu_busy), 32'h1);
        reset = 1'b0;
        flush = 1'b1;
        step();
        check_zero("t6_reset");
        reset = 1'b1;
        flush = 1'b0;
        step();
        check("t6r.s0", slot(0), 32'd0);
        check("t6r.s1", slot(1), 32'd2);
        check("t6r.s2", slot(2), 32'd4);
        check("t6r.li", 32'(lsu_grant_idx), 32'd1);
        check("t6r.clr", 32'(rs_clear), 32'h0017);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
